// File: rtl/dual_fifo_frame_scheduler.sv
// Pulls fixed-length frames from one of two sample FIFOs (L/R) and streams them
// out with Sop/Eop framing, alternating channels when both have data queued.
module dual_fifo_frame_scheduler #(
    parameter int DATA_WIDTH = 24,
    parameter int FRAME_LEN  = 256,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  Clk,
    input  logic                  Clear_in,
    input  logic                  Enable_in,
    input  logic                  L_Empty_in,
    input  logic                  R_Empty_in,
    output logic                  L_ReadEn_out,
    output logic                  R_ReadEn_out,
    input  logic [DATA_WIDTH-1:0] L_Data_in,
    input  logic [DATA_WIDTH-1:0] R_Data_in,
    output logic [DATA_WIDTH-1:0] Out_Data_out,
    output logic                  Out_Valid_out,
    input  logic                  Out_Ready_in,
    output logic                  Out_Sop_out,
    output logic                  Out_Eop_out,
    output logic                  Out_Chan_out,
    output logic                  Busy_out,
    output logic                  FrameDone_out
);

    typedef enum logic [2:0] {IDLE, ARB, RD, CAP, OUT} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_LEN - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 last_chan;
    logic                 sel_empty;
    logic                 rd_issue;

    // The read strobe is combinational so a refilled FIFO is read the same cycle
    // its empty flag drops; Clear_in masks it so no sample is lost on reset.
    assign sel_empty    = Out_Chan_out ? R_Empty_in : L_Empty_in;
    assign rd_issue     = (state == RD) && !sel_empty && !Clear_in;
    assign L_ReadEn_out = rd_issue && !Out_Chan_out;
    assign R_ReadEn_out = rd_issue && Out_Chan_out;
    assign Busy_out     = (state == RD) || (state == CAP) || (state == OUT);

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            state         <= IDLE;
            cnt           <= '0;
            last_chan     <= 1'b1;
            Out_Chan_out  <= 1'b0;
            Out_Data_out  <= '0;
            Out_Valid_out <= 1'b0;
            Out_Sop_out   <= 1'b0;
            Out_Eop_out   <= 1'b0;
            FrameDone_out <= 1'b0;
        end else begin
            FrameDone_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (Enable_in) state <= ARB;
                end
                ARB: begin
                    if (!Enable_in) begin
                        state <= IDLE;
                    end else if (!L_Empty_in || !R_Empty_in) begin
                        // On a tie the channel not served last wins.
                        if (!L_Empty_in && !R_Empty_in) Out_Chan_out <= ~last_chan;
                        else                            Out_Chan_out <= L_Empty_in;
                        cnt   <= '0;
                        state <= RD;
                    end
                end
                RD: begin
                    if (rd_issue) state <= CAP;
                end
                CAP: begin
                    Out_Data_out  <= Out_Chan_out ? R_Data_in : L_Data_in;
                    Out_Valid_out <= 1'b1;
                    Out_Sop_out   <= (cnt == '0);
                    Out_Eop_out   <= (cnt == LAST_CNT);
                    state         <= OUT;
                end
                OUT: begin
                    if (Out_Ready_in) begin
                        Out_Valid_out <= 1'b0;
                        Out_Sop_out   <= 1'b0;
                        Out_Eop_out   <= 1'b0;
                        if (Out_Eop_out) begin
                            cnt           <= '0;
                            last_chan     <= Out_Chan_out;
                            FrameDone_out <= 1'b1;
                            state         <= ARB;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
